// File: rtl/ram_1rw_arbiter.sv
// ram_1rw_arbiter: round-robin req/rel/grant arbiter sharing one single-port
// payload RAM between NUM_REQ clients. The current owner's addr/ce/we/wdata
// are muxed onto the RAM port; read data is broadcast to every client.
// Optional watchdog on grant hold time: define RAM_1RW_ARBITER_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no grant held; arbitrate among req starting at rr pointer
// S_GRANT | owner holds the RAM port until rel[owner] (or watchdog revoke)
// S_TURN  | one forced idle cycle so the last read's data lands before a switch

module ram_1rw_arbiter #(
  parameter  int NUM_REQ        = 2,
  parameter  int AWIDTH         = 11,
  parameter  int DWIDTH         = 8,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int OW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        rel,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [OW-1:0]             owner,
  input  logic [NUM_REQ*AWIDTH-1:0] c_addr,
  input  logic [NUM_REQ-1:0]        c_ce,
  input  logic [NUM_REQ-1:0]        c_we,
  input  logic [NUM_REQ*DWIDTH-1:0] c_wdata,
  output logic [DWIDTH-1:0]         c_rdata,
  output logic [AWIDTH-1:0]         mem_addr,
  output logic                      mem_ce,
  output logic                      mem_we,
  output logic [DWIDTH-1:0]         mem_wdata,
  input  logic [DWIDTH-1:0]         mem_rdata,
  output logic                      timeout
);

  // Parameter sanity: NUM_REQ in 2..8, watchdog needs at least two cycles.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ram_1rw_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [OW:0]   NUM_REQ_W = (OW+1)'(NUM_REQ);
  localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_q, rr_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [OW-1:0]        pick_off;
  logic [OW:0]          pick_sum;
  logic [OW-1:0]        pick_idx;
  logic [OW-1:0]        owner_next;
  logic                 wd_expire;

  logic [AWIDTH-1:0]    addr_arr  [NUM_REQ];
  logic [DWIDTH-1:0]    wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = c_addr[i*AWIDTH +: AWIDTH];
    assign wdata_arr[i] = c_wdata[i*DWIDTH +: DWIDTH];
  end

  // Round-robin pick: rotate req so rr pointer sits at bit 0, take the lowest
  // set bit, then rotate the offset back into an absolute requester index.
  always_comb begin
    req_dbl  = {req, req};
    req_rot  = NUM_REQ'(req_dbl >> rr_q);
    pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = OW'(k);
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    if (pick_sum >= NUM_REQ_W) pick_sum = pick_sum - NUM_REQ_W;
    pick_idx = pick_sum[OW-1:0];
  end

  // After a release the requester just above the owner gets first look.
  assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);

`ifdef RAM_1RW_ARBITER_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_cnt_q;

  // Grant-hold counter: zero outside GRANT, so it starts at 0 on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q != S_GRANT) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + CW'(1);
    end
  end

  // Revoke only when the owner has not released in this same cycle.
  assign wd_expire = (state_q == S_GRANT) && (wd_cnt_q == WD_LAST) && !rel[owner_q];
`else
  assign wd_expire = 1'b0;
`endif

  assign timeout = wd_expire;

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        // Release wins over a simultaneous req from the owner; req dropping
        // alone never releases.
        if (rel[owner_q] || wd_expire) begin
          state_d = S_TURN;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = owner_next;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and grant/owner/rr registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign owner = owner_q;

  // RAM port mux: only the owner reaches the RAM, and only while in GRANT;
  // rst gates it directly so no access can complete once reset is asserted.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst && state_q == S_GRANT) begin
      mem_ce    = c_ce[owner_q];
      mem_we    = c_we[owner_q] & c_ce[owner_q];
      mem_addr  = addr_arr[owner_q];
      mem_wdata = wdata_arr[owner_q];
    end
  end

  assign c_rdata = mem_rdata;

endmodule

// File: tb/tb_ram_1rw_arbiter.sv
// Self-checking bench for ram_1rw_arbiter (NUM_REQ=2) with a behavioural
// 1-cycle-latency RAM model and a read-data scoreboard.
// Watchdog expectations follow RAM_1RW_ARBITER_TIMEOUT_EN.

module tb_ram_1rw_arbiter;

  localparam int NR = 2;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, rel, grant, c_ce, c_we;
  logic            busy, mem_ce, mem_we, timeout;
  logic [0:0]      owner;
  logic [NR*AW-1:0] c_addr;
  logic [NR*DW-1:0] c_wdata;
  logic [DW-1:0]   c_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;

  logic [DW-1:0]   ram     [2048];
  logic [DW-1:0]   exp_mem [2048];
  logic [DW-1:0]   sb_q    [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_1rw_arbiter #(
    .NUM_REQ(NR), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .grant(grant), .busy(busy),
    .owner(owner), .c_addr(c_addr), .c_ce(c_ce), .c_we(c_we), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .timeout(timeout)
  );

  // Behavioural single-port RAM, read data one cycle after ce & ~we.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic ce, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_ce[i] = ce;
    c_we[i] = we;
    c_addr[i*AW +: AW]  = a;
    c_wdata[i*DW +: DW] = d;
  endtask

  task automatic wr_issue(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(i, 1'b1, 1'b1, a, d);
    exp_mem[a] = d;
  endtask

  task automatic rd_issue(input int i, input logic [AW-1:0] a);
    drive(i, 1'b1, 1'b0, a, '0);
    sb_q.push_back(exp_mem[a]);
  endtask

  task automatic rd_check(input string tag);
    if (sb_q.size() == 0) check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    else                  check_eq(tag, 32'(c_rdata), 32'(sb_q.pop_front()));
  endtask

  initial begin
    logic       exp_to;
    logic [1:0] exp_g;
    for (int a = 0; a < 2048; a++) begin
      ram[a]     = '0;
      exp_mem[a] = '0;
    end
    rst = 1'b1; req = '0; rel = '0; c_ce = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_owner", 32'(owner), 32'h0);
    check_eq("rst_timeout", 32'(timeout), 32'h0);
    check_eq("rst_mem_ce", 32'(mem_ce), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_eq("idle_grant", 32'(grant), 32'h0);

    // single requester, write then read in the release cycle
    req = 2'b01;
    tick();
    check_eq("t1_grant", 32'(grant), 32'h1);
    check_eq("t1_busy", 32'(busy), 32'h1);
    check_eq("t1_owner", 32'(owner), 32'h0);
    wr_issue(0, 11'd5, 8'hA5);
    #1;
    check_eq("t1_mem_ce", 32'(mem_ce), 32'h1);
    check_eq("t1_mem_we", 32'(mem_we), 32'h1);
    check_eq("t1_mem_addr", 32'(mem_addr), 32'h5);
    check_eq("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b1, 11'd7, 8'h5A);
    #1;
    check_eq("t3_nonowner_ce", 32'(mem_ce), 32'h0);
    check_eq("t3_nonowner_we", 32'(mem_we), 32'h0);
    tick();
    check_eq("t3_no_leak_wr", 32'(ram[7]), 32'h0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rd_issue(0, 11'd5);
    rel = 2'b01;
    #1;
    check_eq("t3_rd_ce", 32'(mem_ce), 32'h1);
    check_eq("t3_rd_we", 32'(mem_we), 32'h0);
    tick();
    rel = '0; req = '0;
    check_eq("t1_rel_grant", 32'(grant), 32'h0);
    check_eq("t1_rel_busy", 32'(busy), 32'h0);
    rd_check("t3_rdata_turn");
    #1;
    check_eq("t1_turn_mem_ce", 32'(mem_ce), 32'h0);
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    check_eq("t1_idle_grant", 32'(grant), 32'h0);

    // non-owner rel and owner req drop are both ignored
    req = 2'b01;
    tick();
    check_eq("t4_grant", 32'(grant), 32'h1);
    rel = 2'b10; req = 2'b00;
    tick();
    check_eq("t4_hold_grant", 32'(grant), 32'h1);
    check_eq("t4_hold_busy", 32'(busy), 32'h1);
    rel = '0;
    tick();
    check_eq("t4_hold_grant2", 32'(grant), 32'h1);

    // async reset mid-grant with an active access
    drive(0, 1'b1, 1'b0, 11'd5, '0);
    #1;
    check_eq("t5_pre_ce", 32'(mem_ce), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_grant", 32'(grant), 32'h0);
    check_eq("t5_rst_mem_ce", 32'(mem_ce), 32'h0);
    check_eq("t5_rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("t5_rst_busy", 32'(busy), 32'h0);
    check_eq("t5_rst_owner", 32'(owner), 32'h0);
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    rst = 1'b0;

    // both request from reset: rr pointer back at 0 picks requester 0
    req = 2'b11;
    tick();
    check_eq("t2_first", 32'(grant), 32'h1);
    rel = 2'b01;
    tick();
    rel = '0;
    check_eq("t2_turn", 32'(grant), 32'h0);
    tick();
    check_eq("t2_idle", 32'(grant), 32'h0);
    tick();
    check_eq("t2_second", 32'(grant), 32'h2);
    check_eq("t2_second_owner", 32'(owner), 32'h1);
    wr_issue(1, 11'd9, 8'h3C);
    #1;
    check_eq("t2_mem_addr", 32'(mem_addr), 32'h9);
    tick();
    rd_issue(1, 11'd9);
    tick();
    rd_check("t2_rdata");
    drive(1, 1'b0, 1'b0, '0, '0);

    // owner 1 releases with req still high: wrap to 0
    rel = 2'b10;
    tick();
    rel = '0;
    repeat (2) tick();
    check_eq("rr_wrap", 32'(grant), 32'h1);
    rel = 2'b01;
    tick();
    rel = '0;
    repeat (2) tick();
    check_eq("rel_req_lowest", 32'(grant), 32'h2);

    // rel held through TURN and IDLE has no effect there
    rel = 2'b10;
    repeat (3) tick();
    check_eq("rel_idle_ignored", 32'(grant), 32'h1);
    rel = 2'b01; req = 2'b00;
    tick();
    rel = '0;
    repeat (2) tick();
    check_eq("all_idle", 32'(grant), 32'h0);

    // grant held without rel: watchdog revoke or indefinite hold
    req = 2'b01;
    tick();
    req = 2'b00;
    for (int k = 1; k <= 20; k++) begin
`ifdef RAM_1RW_ARBITER_TIMEOUT_EN
      exp_to = (k == TO);
      exp_g  = (k <= TO) ? 2'b01 : 2'b00;
`else
      exp_to = 1'b0;
      exp_g  = 2'b01;
`endif
      check_eq($sformatf("t6_timeout_c%0d", k), 32'(timeout), 32'(exp_to));
      check_eq($sformatf("t6_grant_c%0d", k), 32'(grant), 32'(exp_g));
      tick();
    end

    check_eq("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
